// File: rtl/ad9363_rx_pkg.sv
// Shared types and constants for the AD9363 receive packer.
package ad9363_rx_pkg;

    localparam int IQ_W    = 12;
    localparam int AXIS_W  = 32;
    localparam int ENTRY_W = AXIS_W + 1;

    typedef enum logic [1:0] {IDLE, ARM, WRITE, DROP} rx_state_e;

    typedef struct packed {
        logic              last;
        logic [AXIS_W-1:0] data;
    } rx_entry_t;

    function automatic logic [15:0] sext16(input logic [IQ_W-1:0] x);
        return {{(16-IQ_W){x[IQ_W-1]}}, x};
    endfunction

endpackage

// File: rtl/ad9363_rx_fifo.sv
// Single-clock FIFO; first-word-fall-through through a registered output stage.
module ad9363_rx_fifo
    import ad9363_rx_pkg::*;
#(
    parameter int DEPTH = 1024
) (
    input  logic                   rx_clk_bufg,
    input  logic                   rst,
    input  logic                   wr_en,
    input  logic [ENTRY_W-1:0]     wr_data,
    input  logic                   rd_en,
    output logic [ENTRY_W-1:0]     rd_data,
    output logic                   empty,
    output logic [$clog2(DEPTH):0] level
);

    localparam int AW = $clog2(DEPTH);
    localparam int LW = AW + 1;

    logic [ENTRY_W-1:0] mem [DEPTH];
    logic [AW-1:0]      wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
    logic [LW-1:0]      mem_cnt_q, mem_cnt_d;
    logic               out_vld_q, out_vld_d;
    logic [ENTRY_W-1:0] rd_data_q, rd_data_d;
    logic               load;

    // Output stage refills whenever it is empty or being consumed this cycle.
    always_comb begin
        load      = (mem_cnt_q != '0) && (!out_vld_q || rd_en);
        wr_ptr_d  = wr_ptr_q + AW'(wr_en);
        rd_ptr_d  = rd_ptr_q + AW'(load);
        mem_cnt_d = mem_cnt_q + LW'(wr_en) - LW'(load);
        out_vld_d = load || (out_vld_q && !rd_en);
        rd_data_d = load ? mem[rd_ptr_q] : rd_data_q;
    end

    always_ff @(posedge rx_clk_bufg) begin
        if (wr_en) mem[wr_ptr_q] <= wr_data;
    end

    always_ff @(posedge rx_clk_bufg) begin
        if (rst) begin
            wr_ptr_q  <= '0;
            rd_ptr_q  <= '0;
            mem_cnt_q <= '0;
            out_vld_q <= 1'b0;
            rd_data_q <= '0;
        end else begin
            wr_ptr_q  <= wr_ptr_d;
            rd_ptr_q  <= rd_ptr_d;
            mem_cnt_q <= mem_cnt_d;
            out_vld_q <= out_vld_d;
            rd_data_q <= rd_data_d;
        end
    end

    assign rd_data = rd_data_q;
    assign empty   = !out_vld_q;
    assign level   = mem_cnt_q + LW'(out_vld_q);

endmodule

// File: rtl/ad9363_rx_packer.sv
// Packs 12-bit I/Q pairs into 32-bit words and emits whole packets on AXI4-Stream;
// a packet is admitted only if the buffer can hold all of it, otherwise dropped.
module ad9363_rx_packer
    import ad9363_rx_pkg::*;
#(
    parameter int PKT_LEN    = 256,
    parameter int FIFO_DEPTH = 1024
) (
    input  logic                          rx_clk_bufg,
    input  logic                          rst,
    input  logic                          capture_en,
    input  logic                          adc_valid,
    input  logic [IQ_W-1:0]               adc_data_i1,
    input  logic [IQ_W-1:0]               adc_data_q1,
    output logic [AXIS_W-1:0]             m_axis_tdata,
    output logic                          m_axis_tvalid,
    output logic                          m_axis_tlast,
    input  logic                          m_axis_tready,
    output logic [$clog2(FIFO_DEPTH):0]   fifo_level,
    output logic [15:0]                   pkt_drop_cnt,
    output logic                          overflow,
    output logic                          busy
);

    localparam int LVL_W = $clog2(FIFO_DEPTH) + 1;
    localparam int CNT_W = $clog2(PKT_LEN);
    localparam logic [LVL_W-1:0] ADMIT_MAX = LVL_W'(FIFO_DEPTH - PKT_LEN);
    localparam logic [CNT_W-1:0] LAST_CNT  = CNT_W'(PKT_LEN - 1);

    logic            in_vld_q;
    logic [IQ_W-1:0] in_i_q, in_q_q;
    rx_state_e       state_q, state_d;
    logic [CNT_W-1:0] samp_cnt_q, samp_cnt_d;
    logic [15:0]     drop_cnt_q, drop_cnt_d;
    logic            overflow_q, overflow_d;
    logic            busy_q, busy_d;
    logic            wr_en, rd_en, fifo_empty, is_last, admit;
    rx_entry_t       wr_entry, rd_entry;
    logic [ENTRY_W-1:0] rd_raw;

    always_comb begin
        state_d       = state_q;
        samp_cnt_d    = samp_cnt_q;
        drop_cnt_d    = drop_cnt_q;
        overflow_d    = overflow_q;
        wr_en         = 1'b0;
        is_last       = (samp_cnt_q == LAST_CNT);
        admit         = (fifo_level <= ADMIT_MAX);
        wr_entry.last = is_last && (state_q == WRITE);
        wr_entry.data = {sext16(in_q_q), sext16(in_i_q)};
        if (state_q != IDLE && in_vld_q) samp_cnt_d = samp_cnt_q + CNT_W'(1);
        case (state_q)
            IDLE: begin
                samp_cnt_d = '0;
                if (capture_en) state_d = ARM;
            end
            ARM: begin
                if (!capture_en) begin
                    state_d    = IDLE;
                    samp_cnt_d = '0;
                end else if (in_vld_q) begin
                    // Whole-packet admission: space reserved now covers every later write.
                    if (admit) begin
                        wr_en   = 1'b1;
                        state_d = WRITE;
                    end else begin
                        state_d    = DROP;
                        overflow_d = 1'b1;
                        if (drop_cnt_q != 16'hFFFF) drop_cnt_d = drop_cnt_q + 16'd1;
                    end
                end
            end
            WRITE: begin
                if (in_vld_q) begin
                    wr_en = 1'b1;
                    if (is_last) state_d = ARM;
                end
            end
            DROP: begin
                if (in_vld_q && is_last) state_d = ARM;
            end
            default: state_d = IDLE;
        endcase
        busy_d = (state_d != IDLE);
    end

    always_ff @(posedge rx_clk_bufg) begin
        if (rst) begin
            in_vld_q   <= 1'b0;
            in_i_q     <= '0;
            in_q_q     <= '0;
            state_q    <= IDLE;
            samp_cnt_q <= '0;
            drop_cnt_q <= '0;
            overflow_q <= 1'b0;
            busy_q     <= 1'b0;
        end else begin
            in_vld_q   <= adc_valid;
            in_i_q     <= adc_data_i1;
            in_q_q     <= adc_data_q1;
            state_q    <= state_d;
            samp_cnt_q <= samp_cnt_d;
            drop_cnt_q <= drop_cnt_d;
            overflow_q <= overflow_d;
            busy_q     <= busy_d;
        end
    end

    ad9363_rx_fifo #(.DEPTH(FIFO_DEPTH)) u_fifo (
        .rx_clk_bufg (rx_clk_bufg),
        .rst         (rst),
        .wr_en       (wr_en),
        .wr_data     (wr_entry),
        .rd_en       (rd_en),
        .rd_data     (rd_raw),
        .empty       (fifo_empty),
        .level       (fifo_level)
    );

    assign rd_entry      = rd_raw;
    assign m_axis_tvalid = !fifo_empty;
    assign m_axis_tdata  = rd_entry.data;
    assign m_axis_tlast  = rd_entry.last;
    assign rd_en         = m_axis_tvalid && m_axis_tready;
    assign pkt_drop_cnt  = drop_cnt_q;
    assign overflow      = overflow_q;
    assign busy          = busy_q;

endmodule

// File: tb/tb_ad9363_rx_packer.sv
// Bench for ad9363_rx_packer: directed scenarios plus random gapped traffic against a packet-level model.
module tb_ad9363_rx_packer;

    localparam int PKT_LEN    = 4;
    localparam int FIFO_DEPTH = 8;
    localparam int LVL_W      = $clog2(FIFO_DEPTH) + 1;

    logic              rx_clk_bufg = 1'b0;
    logic              rst = 1'b1, capture_en = 1'b0, adc_valid = 1'b0, m_axis_tready = 1'b0;
    logic [11:0]       adc_data_i1 = '0, adc_data_q1 = '0;
    logic [31:0]       m_axis_tdata;
    logic              m_axis_tvalid, m_axis_tlast, overflow, busy;
    logic [LVL_W-1:0]  fifo_level;
    logic [15:0]       pkt_drop_cnt;

    ad9363_rx_packer #(.PKT_LEN(PKT_LEN), .FIFO_DEPTH(FIFO_DEPTH)) dut (
        .rx_clk_bufg   (rx_clk_bufg),
        .rst           (rst),
        .capture_en    (capture_en),
        .adc_valid     (adc_valid),
        .adc_data_i1   (adc_data_i1),
        .adc_data_q1   (adc_data_q1),
        .m_axis_tdata  (m_axis_tdata),
        .m_axis_tvalid (m_axis_tvalid),
        .m_axis_tlast  (m_axis_tlast),
        .m_axis_tready (m_axis_tready),
        .fifo_level    (fifo_level),
        .pkt_drop_cnt  (pkt_drop_cnt),
        .overflow      (overflow),
        .busy          (busy)
    );

    always #5 rx_clk_bufg = ~rx_clk_bufg;

    int checks = 0, failures = 0;
    logic [32:0] exp_q[$];
    logic [31:0] obs_q[$];
    int n_written = 0, n_read = 0, drops = 0, pos = 0, cyc = 0, obs_lasts = 0;
    int first_vld_cyc = -1, strobe_cyc = 0;
    logic keep = 1'b0, in_pkt = 1'b0;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        if (obs !== exp) begin
            failures++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    function automatic logic [31:0] pack(input logic [11:0] i, input logic [11:0] q);
        logic signed [15:0] si, sq;
        si = $signed(i);
        sq = $signed(q);
        return {sq, si};
    endfunction

    // One clock: drive inputs after the falling edge, then observe the settled outputs.
    // A handshake seen here happens at the next rising edge; the buffer level that the
    // packet-start decision for this step's sample sees is (words written by earlier
    // samples) - (words read up to and including this handshake).
    task automatic step(input logic v, input logic [11:0] i, input logic [11:0] q,
                        input logic rdy, input logic cap, input logic r);
        logic [32:0] e;
        @(negedge rx_clk_bufg);
        adc_valid = v; adc_data_i1 = i; adc_data_q1 = q;
        m_axis_tready = rdy; capture_en = cap; rst = r;
        #1;
        cyc++;
        if (m_axis_tvalid && first_vld_cyc < 0) first_vld_cyc = cyc;
        if (r) begin
            exp_q.delete();
            n_written = 0; n_read = 0; drops = 0; pos = 0; in_pkt = 1'b0;
        end else begin
            if (m_axis_tvalid && m_axis_tready) begin
                n_read++;
                obs_q.push_back(m_axis_tdata);
                if (m_axis_tlast) obs_lasts++;
                chk("sb_occupancy", 64'(exp_q.size() > 0), 64'd1);
                if (exp_q.size() > 0) begin
                    e = exp_q.pop_front();
                    chk("axis_word", {31'd0, m_axis_tlast, m_axis_tdata}, {31'd0, e});
                end
            end
            if (v) begin
                if (pos == 0) begin
                    in_pkt = cap;
                    if (cap) begin
                        keep = (n_written - n_read) <= (FIFO_DEPTH - PKT_LEN);
                        if (!keep) drops++;
                    end
                end
                if (in_pkt) begin
                    if (keep) begin
                        exp_q.push_back({pos == PKT_LEN - 1, pack(i, q)});
                        n_written++;
                    end
                    pos = (pos + 1) % PKT_LEN;
                end
            end
        end
    endtask

    task automatic idle(input int n, input logic rdy, input logic cap);
        for (int k = 0; k < n; k++) step(1'b0, 12'h0, 12'h0, rdy, cap, 1'b0);
    endtask

    initial begin
        for (int k = 0; k < 3; k++) step(1'b0, 12'h0, 12'h0, 1'b0, 1'b0, 1'b1);
        idle(1, 1'b0, 1'b0);
        chk("rst_tvalid", 64'(m_axis_tvalid), 64'd0);
        chk("rst_tlast", 64'(m_axis_tlast), 64'd0);
        chk("rst_tdata", 64'(m_axis_tdata), 64'd0);
        chk("rst_level", 64'(fifo_level), 64'd0);
        chk("rst_drop_cnt", 64'(pkt_drop_cnt), 64'd0);
        chk("rst_overflow", 64'(overflow), 64'd0);
        chk("rst_busy", 64'(busy), 64'd0);

        // Basic packet: two full packets of a fixed pattern, tready held high.
        idle(2, 1'b1, 1'b1);
        first_vld_cyc = -1;
        strobe_cyc    = cyc + 1;
        obs_q.delete();
        for (int k = 0; k < 8; k++) step(1'b1, 12'h7FF, 12'h800, 1'b1, 1'b1, 1'b0);
        idle(6, 1'b1, 1'b1);
        // Visible two edges after the strobe's edge; sampling precedes the edge, hence +3.
        chk("first_tvalid_latency", 64'(first_vld_cyc - strobe_cyc), 64'd3);
        chk("basic_count", 64'(obs_q.size()), 64'd8);
        chk("basic_word0", 64'(obs_q.size() > 0 ? obs_q[0] : 32'h0), 64'hF800_07FF);
        chk("basic_tlasts", 64'(obs_lasts), 64'd2);
        chk("basic_drained", 64'(exp_q.size()), 64'd0);

        // Sign extension corners.
        obs_q.delete();
        step(1'b1, 12'h001, 12'hFFF, 1'b1, 1'b1, 1'b0);
        step(1'b1, 12'h800, 12'h7FF, 1'b1, 1'b1, 1'b0);
        step(1'b1, 12'h000, 12'h000, 1'b1, 1'b1, 1'b0);
        step(1'b1, 12'hFFF, 12'h001, 1'b1, 1'b1, 1'b0);
        idle(6, 1'b1, 1'b1);
        chk("sext_a", 64'(obs_q.size() > 1 ? obs_q[0] : 32'h0), 64'hFFFF_0001);
        chk("sext_b", 64'(obs_q.size() > 1 ? obs_q[1] : 32'h0), 64'h07FF_F800);

        // Backpressure: 4 packets into an 8-entry buffer, two must drop.
        for (int k = 0; k < 16; k++)
            step(1'b1, 12'($urandom), 12'($urandom), 1'b0, 1'b1, 1'b0);
        idle(3, 1'b0, 1'b1);
        chk("bp_drop_cnt", 64'(pkt_drop_cnt), 64'd2);
        chk("bp_drop_model", 64'(pkt_drop_cnt), 64'(drops));
        chk("bp_overflow", 64'(overflow), 64'd1);
        chk("bp_level", 64'(fifo_level), 64'd8);
        idle(12, 1'b1, 1'b1);
        chk("bp_drained", 64'(exp_q.size()), 64'd0);
        chk("bp_level_empty", 64'(fifo_level), 64'd0);

        // Disable mid-packet: the packet still completes, later samples are ignored.
        step(1'b1, 12'h101, 12'h201, 1'b1, 1'b1, 1'b0);
        step(1'b1, 12'h102, 12'h202, 1'b1, 1'b1, 1'b0);
        step(1'b1, 12'h103, 12'h203, 1'b1, 1'b0, 1'b0);
        chk("dis_busy_mid", 64'(busy), 64'd1);
        step(1'b1, 12'h104, 12'h204, 1'b1, 1'b0, 1'b0);
        idle(3, 1'b1, 1'b0);
        chk("dis_busy_fall", 64'(busy), 64'd0);
        for (int k = 0; k < 4; k++) step(1'b1, 12'h3AA, 12'h3BB, 1'b1, 1'b0, 1'b0);
        idle(4, 1'b1, 1'b0);
        chk("dis_drained", 64'(exp_q.size()), 64'd0);
        chk("dis_level", 64'(fifo_level), 64'd0);

        // Gapped random traffic with random backpressure.
        idle(2, 1'b1, 1'b1);
        obs_q.delete();
        obs_lasts = 0;
        for (int k = 0; k < 40; k++) begin
            step(1'b1, 12'($urandom), 12'($urandom), $urandom_range(0, 3) != 0, 1'b1, 1'b0);
            step(1'b0, 12'h0, 12'h0, $urandom_range(0, 3) != 0, 1'b1, 1'b0);
        end
        idle(20, 1'b1, 1'b1);
        chk("gap_drained", 64'(exp_q.size()), 64'd0);
        chk("gap_tlast_ratio", 64'(obs_lasts * PKT_LEN), 64'(obs_q.size()));

        // Reset with a partial packet buffered.
        step(1'b1, 12'h011, 12'h022, 1'b0, 1'b1, 1'b0);
        step(1'b1, 12'h033, 12'h044, 1'b0, 1'b1, 1'b0);
        idle(2, 1'b0, 1'b1);
        chk("prerst_level", 64'(fifo_level), 64'd2);
        step(1'b0, 12'h0, 12'h0, 1'b0, 1'b1, 1'b1);
        idle(1, 1'b0, 1'b1);
        chk("mrst_tvalid", 64'(m_axis_tvalid), 64'd0);
        chk("mrst_level", 64'(fifo_level), 64'd0);
        chk("mrst_drop_cnt", 64'(pkt_drop_cnt), 64'd0);
        chk("mrst_overflow", 64'(overflow), 64'd0);
        chk("mrst_busy", 64'(busy), 64'd0);
        idle(2, 1'b1, 1'b1);
        obs_lasts = 0;
        for (int k = 0; k < 4; k++)
            step(1'b1, 12'($urandom), 12'($urandom), 1'b1, 1'b1, 1'b0);
        idle(6, 1'b1, 1'b1);
        chk("post_rst_drained", 64'(exp_q.size()), 64'd0);
        chk("post_rst_tlasts", 64'(obs_lasts), 64'd1);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
